sync_fifo_ctl: RTL and testbench
================================

# sync_fifo_ctl

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through (FWFT) read mode, and a synchronous flush. It also provides runtime-programmable almost-full/almost-empty thresholds and an occupancy output. It sits between a producer and a consumer in one clock domain and replaces the fixed-depth FIFO wherever level-based flow control is needed.

## Interface
- FIFO_WIDTH, 16, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of entries (≥2; need not be a power of two).
- READ_MODE, FIFO_STD, fifo_mode_e: FIFO_STD (registered read) or FIFO_FWFT.
- CNT_W, $clog2(FIFO_DEPTH+1), width of occupancy and threshold ports (derived, not overridden).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high; highest priority.
- flush  in  1  synchronous clear of contents; priority below rst.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (in FWFT mode: acknowledge of the current head word).
- af_thresh  in  CNT_W  almost-full threshold.
- ae_thresh  in  CNT_W  almost-empty threshold.
- data_out  out  FIFO_WIDTH  read data.
- rd_valid  out  1  data_out holds a valid word.
- wr_ack, overflow, underflow  out  1 each  registered per-request status.
- full, empty, almostfull, almostempty  out  1 each  combinational status from level.
- level  out  CNT_W  current occupancy.

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. full/empty are the values at the start of the cycle.
- Both accepted in the same cycle: level unchanged, both pointers advance.
- Full + wr_en + rd_en: only the read is accepted, level decrements, overflow=1. Empty + both: only the write is accepted, level increments, underflow=1.
- Pointers: 0..FIFO_DEPTH-1. They wrap by explicit compare (ptr==FIFO_DEPTH-1 → 0), never by bit truncation.
- full = (level==FIFO_DEPTH); empty = (level==0); almostfull = (level >= af_thresh); almostempty = (level <= ae_thresh). Thresholds are compared unsigned and live; no clamping.
- wr_ack=1 the cycle after an accepted write, else 0. overflow=1 the cycle after wr_en was rejected, else 0. underflow=1 the cycle after rd_en was rejected, else 0.
- FIFO_STD read mode:
  - data_out is registered and loads mem[rd_ptr] on an accepted read.
  - It holds its value otherwise.
  - rd_valid=1 exactly the cycle after an accepted read.
- FIFO_FWFT read mode:
  - data_out = mem[rd_ptr] combinationally.
  - rd_valid = !empty.
  - An accepted read pops the head, and the next word appears on data_out the following cycle.
  - underflow follows the same rule as FIFO_STD.
- flush (when rst=0):
  - Next cycle: level=0 and pointers=0. wr_ack, overflow, underflow and rd_valid are 0.
  - Any wr_en/rd_en in the flush cycle is ignored and produces no status.
  - FIFO_STD data_out holds its last value.
  - Memory contents are not cleared.
- rst: same effect as flush, and additionally data_out=0 (FIFO_STD).

## Timing
- Reset values: level=0, empty=1, full=0, almostfull=(0>=af_thresh), almostempty=1, wr_ack=0, overflow=0, underflow=0, rd_valid=0, data_out=0 (FIFO_STD) / don't-care masked by rd_valid=0 (FWFT).
- Write-to-read latency:
  - FIFO_STD: a word written in cycle N can be read-accepted in N+1, with data on data_out in N+2.
  - FIFO_FWFT: the word appears on data_out in N+1.
- level, full and empty update one cycle after the accepted operation. Status flags (wr_ack, overflow, underflow) have one-cycle latency.
- Reset or flush asserted mid-burst takes effect at the next edge; the in-flight request is dropped with no status.
- No combinational path from wr_en/rd_en to any output except FWFT rd_valid/data_out, which depend only on registered state.

## Structure
- shared_pkg: fifo_mode_e typedef (FIFO_STD, FIFO_FWFT) and default FIFO_WIDTH/FIFO_DEPTH constants.
- Sub-module fifo_wrap_ptr (parameter DEPTH; ports clk, rst, clr, inc, ptr). It is instantiated for wr_ptr and rd_ptr and holds the explicit wrap logic.
- Top module holds memory, level counter, status flags and the read-mode generate branch.

## Test plan
- DEPTH=6, WIDTH=16, FIFO_STD:
  - write 0xA000..0xA005 → full=1 after the 6th write.
  - A 7th wr_en → overflow=1, wr_ack=0, level stays 6.
  - Read 6 → data_out 0xA000..0xA005 in order, then empty=1.
- DEPTH=6 wrap-around: run 20 interleaved single writes/reads (so pointers pass index 5→0 three times) → data order preserved, level never exceeds 1.
- Simultaneous wr_en+rd_en:
  - At level=3 → level stays 3, wr_ack=1.
  - At full → level 6→5, overflow=1.
  - At empty → level 0→1, underflow=1.
- FWFT: write 0x1234 into an empty FIFO in cycle N → rd_valid=1 and data_out=0x1234 in N+1 with no rd_en. rd_en in N+1 → rd_valid=0 in N+2.
- Thresholds: af_thresh=4, ae_thresh=1.
  - Fill 0→5 → almostfull rises at level 4.
  - almostempty is 1 at levels 0–1 only.
  - Change af_thresh to 2 at level 5 → almostfull stays 1.
- Flush at level 4 with simultaneous wr_en=1 → next cycle level=0, empty=1, wr_ack=0.
- Reset mid-write → same result, plus data_out=0.

Source files
------------

// File: rtl/shared_pkg.sv
// shared_pkg: read-mode type and default geometry shared by the FIFO family.
package shared_pkg;
   typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;
   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: index 0..DEPTH-1 that wraps by explicit compare, so any depth works.
module fifo_wrap_ptr #(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);
   logic [PW-1:0] ptr_q, ptr_d;
   always_comb begin
      ptr_d = clr ? '0 : !inc ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
   assign ptr = ptr_q;
endmodule

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with arbitrary depth, STD/FWFT read modes,
// synchronous flush, programmable almost-full/almost-empty levels and occupancy.
module sync_fifo_ctl
   import shared_pkg::*;
#(
   parameter int         FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter fifo_mode_e READ_MODE  = FIFO_STD,
   localparam int        CNT_W      = $clog2(FIFO_DEPTH + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0]      level_q, level_d;
   logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic                  wr_acc, rd_acc;
   assign full        = level_q == CNT_W'(FIFO_DEPTH);
   assign empty       = level_q == '0;
   assign almostfull  = level_q >= af_thresh;
   assign almostempty = level_q <= ae_thresh;
   assign level       = level_q;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   // A flush cycle swallows any request without producing status.
   always_comb begin
      wr_acc      = wr_en && !full && !flush;
      rd_acc      = rd_en && !empty && !flush;
      level_d     = flush ? '0 : level_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en && full && !flush;
      underflow_d = rd_en && empty && !flush;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr] <= data_in;
   end
   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
      .clk(clk), .rst(rst), .clr(flush), .inc(wr_acc), .ptr(wr_ptr)
   );
   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
      .clk(clk), .rst(rst), .clr(flush), .inc(rd_acc), .ptr(rd_ptr)
   );
   if (READ_MODE == FIFO_STD) begin : g_std
      logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
      logic                  rd_valid_q, rd_valid_d;
      always_comb begin
         data_out_d = rd_acc ? mem_q[rd_ptr] : data_out_q;
         rd_valid_d = rd_acc;
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
         end
      end
      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
   end else begin : g_fwft
      // Head word is exposed straight from memory; only registered state feeds it.
      assign data_out = mem_q[rd_ptr];
      assign rd_valid = !empty;
   end
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: STD and FWFT instances (depth 6) driven in lockstep and
// checked against a queue-based reference model.
module tb_sync_fifo_ctl;
   import shared_pkg::*;
   localparam int D = 6;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [15:0] data_in = '0;
   logic [2:0] af = 3'd4, ae = 3'd1;
   logic [15:0] dout_s, dout_f;
   logic rv_s, wack_s, ovf_s, unf_s, full_s, empty_s, af_s, ae_s;
   logic rv_f, wack_f, ovf_f, unf_f, full_f, empty_f, af_f, ae_f;
   logic [2:0] lvl_s, lvl_f;
   int errors = 0, checks = 0;
   logic [15:0] q[$];
   logic e_wack = 0, e_ovf = 0, e_unf = 0, e_rv = 0;
   logic [15:0] e_dout = '0;

   always #5 clk = ~clk;

   sync_fifo_ctl #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .READ_MODE(FIFO_STD)) u_std (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .af_thresh(af), .ae_thresh(ae), .data_out(dout_s), .rd_valid(rv_s), .wr_ack(wack_s),
      .overflow(ovf_s), .underflow(unf_s), .full(full_s), .empty(empty_s),
      .almostfull(af_s), .almostempty(ae_s), .level(lvl_s)
   );
   sync_fifo_ctl #(.FIFO_WIDTH(16), .FIFO_DEPTH(D), .READ_MODE(FIFO_FWFT)) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .af_thresh(af), .ae_thresh(ae), .data_out(dout_f), .rd_valid(rv_f), .wr_ack(wack_f),
      .overflow(ovf_f), .underflow(unf_f), .full(full_f), .empty(empty_f),
      .almostfull(af_f), .almostempty(ae_f), .level(lvl_f)
   );

   task automatic drive(input logic we, input logic re, input logic [15:0] din,
                        input logic fl, input logic rs);
      bit was_full, was_empty, wa, ra;
      @(negedge clk);
      wr_en = we; rd_en = re; data_in = din; flush = fl; rst = rs;
      @(posedge clk);
      if (rs || fl) begin
         q.delete();
         e_wack = 0; e_ovf = 0; e_unf = 0; e_rv = 0;
         if (rs) e_dout = '0;
      end else begin
         was_full = q.size() == D;
         was_empty = q.size() == 0;
         wa = we && !was_full;
         ra = re && !was_empty;
         if (ra) e_dout = q.pop_front();
         if (wa) q.push_back(din);
         e_wack = wa; e_ovf = we && was_full; e_unf = re && was_empty; e_rv = ra;
      end
      #1;
   endtask

   task automatic test_reset;
      drive(0, 0, 16'h0, 0, 1);
      drive(0, 0, 16'h0, 0, 1);
      drive(0, 0, 16'h0, 0, 0);
      checks++; if (lvl_s !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", lvl_s); end
      checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty_s); end
      checks++; if (full_s !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full_s); end
      checks++; if (ae_s !== 1'b1) begin errors++; $display("FAIL rst_ae got %b want 1", ae_s); end
      checks++; if (af_s !== 1'b0) begin errors++; $display("FAIL rst_af got %b want 0", af_s); end
      checks++; if ({wack_s, ovf_s, unf_s} !== 3'b000) begin errors++; $display("FAIL rst_status got %b want 000", {wack_s, ovf_s, unf_s}); end
      checks++; if (rv_s !== 1'b0) begin errors++; $display("FAIL rst_rv_std got %b want 0", rv_s); end
      checks++; if (dout_s !== 16'h0) begin errors++; $display("FAIL rst_dout got %h want 0000", dout_s); end
      checks++; if (rv_f !== 1'b0) begin errors++; $display("FAIL rst_rv_fwft got %b want 0", rv_f); end
   endtask

   task automatic test_fill_std;
      for (int i = 0; i < D; i++) begin
         drive(1, 0, 16'hA000 + 16'(i), 0, 0);
         checks++; if (int'(lvl_s) !== i + 1) begin errors++; $display("FAIL fill_level got %0d want %0d", lvl_s, i + 1); end
         checks++; if (wack_s !== 1'b1) begin errors++; $display("FAIL fill_wack got %b want 1", wack_s); end
      end
      checks++; if (full_s !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_s); end
      drive(1, 0, 16'hAFFF, 0, 0);
      checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf got %b want 1", ovf_s); end
      checks++; if (wack_s !== 1'b0) begin errors++; $display("FAIL ovf_wack got %b want 0", wack_s); end
      checks++; if (lvl_s !== 3'd6) begin errors++; $display("FAIL ovf_level got %0d want 6", lvl_s); end
      for (int i = 0; i < D; i++) begin
         drive(0, 1, 16'h0, 0, 0);
         checks++; if (dout_s !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL read_data got %h want %h", dout_s, 16'hA000 + 16'(i)); end
         checks++; if (rv_s !== 1'b1) begin errors++; $display("FAIL read_rv got %b want 1", rv_s); end
      end
      checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty_s); end
      drive(0, 0, 16'h0, 0, 0);
      checks++; if (rv_s !== 1'b0) begin errors++; $display("FAIL idle_rv got %b want 0", rv_s); end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 16'hB000 + 16'(i), 0, 0);
         checks++; if (lvl_s !== 3'd1) begin errors++; $display("FAIL wrap_level got %0d want 1", lvl_s); end
         checks++; if (dout_f !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL wrap_fwft got %h want %h", dout_f, 16'hB000 + 16'(i)); end
         drive(0, 1, 16'h0, 0, 0);
         checks++; if (dout_s !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL wrap_data got %h want %h", dout_s, 16'hB000 + 16'(i)); end
         checks++; if (lvl_s !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", lvl_s); end
      end
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 3; i++) drive(1, 0, 16'hC000 + 16'(i), 0, 0);
      drive(1, 1, 16'hC003, 0, 0);
      checks++; if (lvl_s !== 3'd3) begin errors++; $display("FAIL sim3_level got %0d want 3", lvl_s); end
      checks++; if (wack_s !== 1'b1) begin errors++; $display("FAIL sim3_wack got %b want 1", wack_s); end
      checks++; if (dout_s !== 16'hC000) begin errors++; $display("FAIL sim3_data got %h want c000", dout_s); end
      for (int i = 4; i < 7; i++) drive(1, 0, 16'hC000 + 16'(i), 0, 0);
      drive(1, 1, 16'hCFFF, 0, 0);
      checks++; if (lvl_s !== 3'd5) begin errors++; $display("FAIL simfull_level got %0d want 5", lvl_s); end
      checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL simfull_ovf got %b want 1", ovf_s); end
      checks++; if (wack_s !== 1'b0) begin errors++; $display("FAIL simfull_wack got %b want 0", wack_s); end
      checks++; if (dout_s !== 16'hC001) begin errors++; $display("FAIL simfull_data got %h want c001", dout_s); end
      for (int i = 0; i < 5; i++) drive(0, 1, 16'h0, 0, 0);
      checks++; if (dout_s !== 16'hC006) begin errors++; $display("FAIL simdrain_data got %h want c006", dout_s); end
      drive(1, 1, 16'hC0EE, 0, 0);
      checks++; if (lvl_s !== 3'd1) begin errors++; $display("FAIL simempty_level got %0d want 1", lvl_s); end
      checks++; if (unf_s !== 1'b1) begin errors++; $display("FAIL simempty_unf got %b want 1", unf_s); end
      checks++; if (rv_s !== 1'b0) begin errors++; $display("FAIL simempty_rv got %b want 0", rv_s); end
   endtask

   task automatic test_fwft;
      drive(0, 0, 16'h0, 1, 0);
      checks++; if (rv_f !== 1'b0) begin errors++; $display("FAIL fwft_flush_rv got %b want 0", rv_f); end
      drive(1, 0, 16'h1234, 0, 0);
      checks++; if (rv_f !== 1'b1) begin errors++; $display("FAIL fwft_rv got %b want 1", rv_f); end
      checks++; if (dout_f !== 16'h1234) begin errors++; $display("FAIL fwft_data got %h want 1234", dout_f); end
      drive(0, 1, 16'h0, 0, 0);
      checks++; if (rv_f !== 1'b0) begin errors++; $display("FAIL fwft_pop_rv got %b want 0", rv_f); end
      checks++; if (unf_f !== 1'b0) begin errors++; $display("FAIL fwft_unf got %b want 0", unf_f); end
      drive(0, 1, 16'h0, 0, 0);
      checks++; if (unf_f !== 1'b1) begin errors++; $display("FAIL fwft_underflow got %b want 1", unf_f); end
   endtask

   task automatic test_thresholds;
      af = 3'd4; ae = 3'd1;
      drive(0, 0, 16'h0, 1, 0);
      for (int i = 0; i <= 5; i++) begin
         checks++; if (af_s !== (i >= 4)) begin errors++; $display("FAIL af_at_%0d got %b want %b", i, af_s, i >= 4); end
         checks++; if (ae_s !== (i <= 1)) begin errors++; $display("FAIL ae_at_%0d got %b want %b", i, ae_s, i <= 1); end
         if (i < 5) drive(1, 0, 16'hD000 + 16'(i), 0, 0);
      end
      af = 3'd2;
      #1;
      checks++; if (af_s !== 1'b1) begin errors++; $display("FAIL af_lowered got %b want 1", af_s); end
      af = 3'd4;
   endtask

   task automatic test_flush;
      drive(0, 1, 16'h0, 0, 0);
      checks++; if (lvl_s !== 3'd4) begin errors++; $display("FAIL preflush_level got %0d want 4", lvl_s); end
      drive(1, 0, 16'hEEEE, 1, 0);
      checks++; if (lvl_s !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", lvl_s); end
      checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty_s); end
      checks++; if (wack_s !== 1'b0) begin errors++; $display("FAIL flush_wack got %b want 0", wack_s); end
      checks++; if (dout_s !== 16'hD000) begin errors++; $display("FAIL flush_hold got %h want d000", dout_s); end
      checks++; if (rv_s !== 1'b0) begin errors++; $display("FAIL flush_rv got %b want 0", rv_s); end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) drive(1, 0, 16'hF000 + 16'(i), 0, 0);
      drive(0, 1, 16'h0, 0, 0);
      drive(1, 0, 16'hF00F, 0, 1);
      checks++; if (lvl_s !== 3'd0) begin errors++; $display("FAIL rstmid_level got %0d want 0", lvl_s); end
      checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", empty_s); end
      checks++; if (wack_s !== 1'b0) begin errors++; $display("FAIL rstmid_wack got %b want 0", wack_s); end
      checks++; if (dout_s !== 16'h0) begin errors++; $display("FAIL rstmid_dout got %h want 0000", dout_s); end
      drive(0, 0, 16'h0, 0, 0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 400; n++) begin
         if (n % 16 == 0) begin af = 3'($urandom_range(0, 7)); ae = 3'($urandom_range(0, 7)); end
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
         checks++; if (int'(lvl_s) !== q.size() || lvl_f !== lvl_s) begin errors++; $display("FAIL rnd_level got %0d/%0d want %0d", lvl_s, lvl_f, q.size()); end
         checks++; if ({full_s, empty_s} !== {q.size() == D, q.size() == 0}) begin errors++; $display("FAIL rnd_fe got %b%b want %b%b", full_s, empty_s, q.size() == D, q.size() == 0); end
         checks++; if ({af_s, ae_s} !== {q.size() >= int'(af), q.size() <= int'(ae)}) begin errors++; $display("FAIL rnd_thresh got %b%b at level %0d", af_s, ae_s, q.size()); end
         checks++; if ({wack_s, ovf_s, unf_s} !== {e_wack, e_ovf, e_unf} || {wack_f, ovf_f, unf_f} !== {e_wack, e_ovf, e_unf}) begin errors++; $display("FAIL rnd_status got %b/%b want %b", {wack_s, ovf_s, unf_s}, {wack_f, ovf_f, unf_f}, {e_wack, e_ovf, e_unf}); end
         checks++; if (rv_s !== e_rv || dout_s !== e_dout) begin errors++; $display("FAIL rnd_std got %b %h want %b %h", rv_s, dout_s, e_rv, e_dout); end
         checks++; if (rv_f !== (q.size() != 0) || (q.size() != 0 && dout_f !== q[0])) begin errors++; $display("FAIL rnd_fwft got %b %h want %b", rv_f, dout_f, q.size() != 0); end
      end
   endtask

   initial begin
      test_reset;
      test_fill_std;
      test_wrap;
      test_simultaneous;
      test_fwft;
      test_thresholds;
      test_flush;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
